// File: rtl/m68k_bus_ctrl.sv
// Bus controller between the 68000 soft core and the on-chip boot ROM.
// Decodes core cycles, sequences ROM reads and terminates each cycle with DTACK or BERR.
module m68k_bus_ctrl #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter int          ROM_AW         = 11,
    parameter int          ROM_LATENCY    = 1,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    output logic [15:0] cpu_data_in,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [31:0] rom_addr,
    output logic        rom_enable,
    input  logic [15:0] rom_data,
    input  logic        rom_berr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_BERR = 3'd3,
        ST_MISS = 3'd4
    } state_t;

    localparam logic [3:0] LAT_C = 4'(ROM_LATENCY);
    localparam logic [9:0] TMO_C = 10'(TIMEOUT_CYCLES);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [9:0]  tcnt_r;
    logic        start_s;
    logic        hit_s;

    assign start_s = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n);
    assign hit_s   = (cpu_addr[31:ROM_AW] == ROM_BASE[31:ROM_AW]);

    // Cycle sequencer; cnt_r counts down the ROM latency so capture lands ROM_LATENCY+1 edges after the start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            tcnt_r      <= 10'd0;
            cpu_data_in <= 16'h0000;
            cpu_dtack_n <= 1'b1;
            cpu_berr_n  <= 1'b1;
            rom_addr    <= 32'h0000_0000;
            rom_enable  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (hit_s) begin
                            if (cpu_rw) begin
                                state_r    <= ST_WAIT;
                                rom_addr   <= cpu_addr;
                                rom_enable <= 1'b1;
                                cnt_r      <= LAT_C;
                            end else begin
                                state_r    <= ST_BERR;
                                cpu_berr_n <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_MISS;
                            tcnt_r  <= 10'd1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cpu_as_n) begin
                        state_r    <= ST_IDLE;
                        rom_enable <= 1'b0;
                        cnt_r      <= 4'd0;
                    end else if (cnt_r == 4'd0) begin
                        cpu_data_in <= rom_data;
                        rom_enable  <= 1'b0;
                        if (rom_berr) begin
                            state_r    <= ST_BERR;
                            cpu_berr_n <= 1'b0;
                        end else begin
                            state_r     <= ST_ACK;
                            cpu_dtack_n <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (cpu_as_n) begin
                        state_r     <= ST_IDLE;
                        cpu_dtack_n <= 1'b1;
                    end else begin
                        state_r <= ST_ACK;
                    end
                end
                ST_BERR: begin
                    if (cpu_as_n) begin
                        state_r    <= ST_IDLE;
                        cpu_berr_n <= 1'b1;
                    end else begin
                        state_r <= ST_BERR;
                    end
                end
                ST_MISS: begin
                    // An AS negation on the timeout edge still counts as the core giving up first.
                    if (cpu_as_n) begin
                        state_r <= ST_IDLE;
                        tcnt_r  <= 10'd0;
                    end else if (tcnt_r == TMO_C) begin
                        state_r    <= ST_BERR;
                        cpu_berr_n <= 1'b0;
                        tcnt_r     <= 10'd0;
                    end else begin
                        tcnt_r <= tcnt_r + 10'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    tcnt_r      <= 10'd0;
                    cpu_dtack_n <= 1'b1;
                    cpu_berr_n  <= 1'b1;
                    rom_enable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Self-checking bench for m68k_bus_ctrl: a latency-1 and a latency-3 instance share the core bus,
// each with its own pipelined ROM model; results are checked against a transaction-level predictor.
module tb_m68k_bus_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] cpu_addr;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic        err_inject;

    logic [15:0] data1, data3, rom_data1, rom_data3;
    logic        dtack1, dtack3, berr1, berr3, en1, en3, rom_berr1, rom_berr3;
    logic [31:0] raddr1, raddr3;

    int          sel;
    int          errors;
    int          checks;

    localparam int TMO3 = 8;

    m68k_bus_ctrl #(.ROM_LATENCY(1), .TIMEOUT_CYCLES(64)) dut1 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
        .cpu_data_in(data1), .cpu_dtack_n(dtack1), .cpu_berr_n(berr1),
        .rom_addr(raddr1), .rom_enable(en1), .rom_data(rom_data1), .rom_berr(rom_berr1)
    );

    m68k_bus_ctrl #(.ROM_LATENCY(3), .TIMEOUT_CYCLES(TMO3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
        .cpu_data_in(data3), .cpu_dtack_n(dtack3), .cpu_berr_n(berr3),
        .rom_addr(raddr3), .rom_enable(en3), .rom_data(rom_data3), .rom_berr(rom_berr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [31:0] a);
        return {a[15:1], 1'b0} + 16'd2;
    endfunction

    // ROM models: an N-stage pipeline that advances only while its clock enable is high.
    logic [15:0] p1;
    logic        pe1;
    logic [15:0] p3 [0:2];
    logic [2:0]  pe3;
    always @(posedge clk) begin
        if (en1) begin
            p1  <= rom_fn(raddr1);
            pe1 <= err_inject;
        end
        if (en3) begin
            p3[0] <= rom_fn(raddr3);
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            pe3   <= {pe3[1:0], err_inject};
        end
    end
    assign rom_data1 = p1;
    assign rom_berr1 = pe1;
    assign rom_data3 = p3[2];
    assign rom_berr3 = pe3[2];

    logic [15:0] data_s;
    logic        dtack_s, berr_s, en_s;
    logic [31:0] raddr_s;
    assign data_s  = (sel == 1) ? data3  : data1;
    assign dtack_s = (sel == 1) ? dtack3 : dtack1;
    assign berr_s  = (sel == 1) ? berr3  : berr1;
    assign en_s    = (sel == 1) ? en3    : en1;
    assign raddr_s = (sel == 1) ? raddr3 : raddr1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level predictor: outcome (0 = DTACK, 1 = BERR) and edges from the start edge to the strobe.
    task automatic predict(input int s, input logic [31:0] a, input logic rw, input logic e,
                           output int kind, output int edges, output logic [15:0] d);
        int lat;
        int tmo;
        lat = (s == 1) ? 3 : 1;
        tmo = (s == 1) ? TMO3 : 64;
        d   = rom_fn(a);
        if (a >= 32'h0000_0800) begin
            kind = 1; edges = tmo;
        end else if (!rw) begin
            kind = 1; edges = 1;
        end else begin
            kind = e ? 1 : 0; edges = 1 + lat;
        end
    endtask

    task automatic drive_start(input logic [31:0] a, input logic rw);
        int u;
        u = $urandom_range(0, 2);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_as_n  = 1'b0;
        cpu_uds_n = (u == 2);
        cpu_lds_n = (u == 1);
    endtask

    task automatic release_as();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
    endtask

    // One full core cycle: start, wait for termination, check timing/data, negate AS, check release.
    task automatic run_txn(input int s, input logic [31:0] a, input logic rw, input logic e,
                           input int exp_kind, input int exp_edges, input logic [15:0] exp_data);
        int   k;
        logic seen;
        logic en_seen;
        logic rd_hit;
        @(negedge clk);
        sel        = s;
        err_inject = e;
        drive_start(a, rw);
        @(posedge clk);
        #1;
        en_seen = en_s;
        k       = 0;
        seen    = 1'b0;
        while (!seen && k < 1100) begin
            @(posedge clk);
            #1;
            k++;
            if (en_s) en_seen = 1'b1;
            if (!dtack_s || !berr_s) seen = 1'b1;
        end
        rd_hit = rw && (a < 32'h0000_0800);
        check("terminated", 32'(seen), 32'd1);
        check("edges", 32'(k), 32'(exp_edges));
        check("berr_n", 32'(berr_s), 32'(exp_kind == 0));
        check("dtack_n", 32'(dtack_s), 32'(exp_kind == 1));
        check("rom_en_off", 32'(en_s), 32'd0);
        check("rom_en_seen", 32'(en_seen), 32'(rd_hit));
        if (rd_hit) check("rom_addr", raddr_s, a);
        if (exp_kind == 0) check("data", 32'(data_s), 32'(exp_data));
        @(negedge clk);
        release_as();
        @(posedge clk);
        #1;
        check("release", {30'd0, dtack_s, berr_s}, 32'd3);
    endtask

    typedef struct {
        int          s;
        logic [31:0] a;
        logic        rw;
        logic        e;
        int          kind;
        int          edges;
        logic [15:0] d;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          kind;
        int          edges;
        int          k;
        logic        bad;
        logic [15:0] d;
        logic [15:0] prev;
        logic [31:0] a;
        logic        rw;
        logic        e;
        int          s;

        errors = 0; checks = 0; sel = 0; err_inject = 1'b0;
        cpu_addr = 32'h0; cpu_rw = 1'b1;
        release_as();
        reset_n = 1'b0;
        vecs[0] = '{0, 32'h0000_0006, 1'b1, 1'b0, 0, 2,  16'h0008};
        vecs[1] = '{0, 32'h0000_0010, 1'b0, 1'b0, 1, 1,  16'h0000};
        vecs[2] = '{0, 32'h0010_0000, 1'b1, 1'b0, 1, 64, 16'h0000};
        vecs[3] = '{0, 32'h0000_0020, 1'b1, 1'b1, 1, 2,  16'h0000};
        vecs[4] = '{1, 32'h0000_0040, 1'b1, 1'b0, 0, 4,  16'h0042};
        vecs[5] = '{1, 32'h0000_7000, 1'b1, 1'b0, 1, TMO3, 16'h0000};
        vecs[6] = '{1, 32'h0000_07FE, 1'b0, 1'b0, 1, 1,  16'h0000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_dtack", 32'(dtack1), 32'd1);
        check("rst_berr", 32'(berr1), 32'd1);
        check("rst_data", 32'(data1), 32'd0);
        check("rst_raddr", raddr1, 32'd0);
        check("rst_en", 32'(en1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].s, vecs[i].a, vecs[i].rw, vecs[i].e, vecs[i].kind, vecs[i].edges, vecs[i].d);

        // Unmapped read given up after 10 clocks: no strobe may ever appear.
        @(negedge clk);
        sel = 0;
        drive_start(32'h0010_0000, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!dtack1 || !berr1) bad = 1'b1;
        end
        @(negedge clk);
        release_as();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (!dtack1 || !berr1) bad = 1'b1;
        end
        check("miss_abort_silent", 32'(bad), 32'd0);

        // Abort in WAIT, then a back-to-back read on the first IDLE edge.
        prev = data1;
        @(negedge clk);
        drive_start(32'h0000_0006, 1'b1);
        @(posedge clk);
        @(negedge clk);
        release_as();
        @(posedge clk);
        #1;
        check("abort_silent", {30'd0, dtack1, berr1}, 32'd3);
        check("abort_en", 32'(en1), 32'd0);
        check("abort_data", 32'(data1), 32'(prev));
        @(negedge clk);
        drive_start(32'h0000_0002, 1'b1);
        @(posedge clk);
        k = 0;
        bad = 1'b0;
        while (k < 20 && dtack1 && berr1) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b2b_edges", 32'(k), 32'd2);
        check("b2b_dtack", 32'(dtack1), 32'd0);
        check("b2b_data", 32'(data1), 32'h0004);

        // Reset asserted while DTACK is held low.
        check("pre_rst_data", 32'(data1), 32'h0004);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_dtack", 32'(dtack1), 32'd1);
        check("mid_rst_en", 32'(en1), 32'd0);
        check("mid_rst_data", 32'(data1), 32'd0);
        check("mid_rst_berr", 32'(berr1), 32'd1);
        release_as();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            s  = int'($urandom_range(0, 1));
            rw = ($urandom_range(0, 4) != 0);
            e  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 8)
                a = {21'd0, 10'($urandom_range(0, 1023)), 1'b0};
            else
                a = 32'h0000_0800 + {15'd0, 16'($urandom), 1'b0};
            predict(s, a, rw, e, kind, edges, d);
            run_txn(s, a, rw, e, kind, edges, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
